// File: rtl/motor_sense_pkg.sv
// motor_sense_pkg: register map and edge-type encodings shared by the motor sense port
package motor_sense_pkg;
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/motor_sense_debounce.sv
// motor_sense_debounce: one-bit filter, output follows input after CYCLES consecutive differing clocks
module motor_sense_debounce #(
  parameter int CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  localparam int CW = $clog2(CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (d == q) begin
      cnt <= '0;
    end else if (cnt == CW'(CYCLES - 1)) begin
      cnt <= '0;
      q   <= d;
    end else begin
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/motor_sense_pio.sv
// motor_sense_pio: Avalon-MM sense input port with edge capture and maskable irq
// Optional input filter enabled by defining MOTOR_SENSE_DEBOUNCE_EN.
module motor_sense_pio
  import motor_sense_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  logic [WIDTH-1:0] s1, s2, cond, prev, rise, fall, sel, clr, irq_mask, edge_cap;
  logic [2:0]       vld;
  logic [31:0]      rd;
  logic             wr;
  logic             unused_ok;
  assign unused_ok = ^{writedata, DEBOUNCE_CYCLES};
  assign wr = chipselect & ~write_n;
`ifdef MOTOR_SENSE_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    motor_sense_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset_n(reset_n), .d(s2[i]), .q(cond[i])
    );
  end
`else
  assign cond = s2;
`endif
  always_comb begin
    rise = cond & ~prev;
    fall = ~cond & prev;
    sel  = EDGE_TYPE == EDGE_ANY ? (rise | fall) : EDGE_TYPE == EDGE_FALL ? fall : rise;
    clr  = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    rd   = '0;
    rd[WIDTH-1:0] = address == ADDR_DATA    ? cond :
                    address == ADDR_RSVD    ? '0 :
                    address == ADDR_IRQMASK ? irq_mask : edge_cap;
  end
  // vld[2] marks prev as holding a real sample, so reset release never looks like an edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1       <= '0;
      s2       <= '0;
      prev     <= '0;
      vld      <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      s1       <= in_port;
      s2       <= s1;
      prev     <= cond;
      vld      <= {vld[1:0], 1'b1};
      if (wr && address == ADDR_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
      edge_cap <= (edge_cap & ~clr) | (vld[2] ? sel : '0);
      irq      <= |(edge_cap & irq_mask);
      readdata <= rd;
    end
endmodule

// File: tb/tb_motor_sense_pio.sv
// tb_motor_sense_pio: directed checks of a rising-edge and an any-edge motor_sense_pio
module tb_motor_sense_pio;
`ifdef MOTOR_SENSE_DEBOUNCE_EN
  localparam int DB  = 8;
  localparam int LAT = 11;
`else
  localparam int DB  = 1000;
  localparam int LAT = 3;
`endif
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata, rd0, rd1, v0, v1;
  logic [3:0]  in_port;
  logic        irq0, irq1;
  int          errors = 0, checks = 0;
  always #5 clk = ~clk;
  motor_sense_pio #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0)
  );
  motor_sense_pio #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DB)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(in_port), .irq(irq1)
  );
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask
  task automatic rd(input logic [1:0] a);
    address = a;
    tick();
    v0 = rd0; v1 = rd1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 4'hF;
    tick(3);
    check("rst_readdata", rd0, 32'h0);
    check("rst_irq", {31'b0, irq0}, 32'h0);
    reset_n = 1'b1;
    tick();
    rd(2'd3);
    check("rst_edgecap", v0, 32'h0);
    check("rst_edgecap_any", v1, 32'h0);
    rd(2'd2);
    check("rst_mask", v0, 32'h0);
    rd(2'd1);
    check("rst_rsvd", v0, 32'h0);
    tick(12);
    rd(2'd0);
    check("rst_data", v0, 32'hF);
    check("rst_irq_after", {31'b0, irq0}, 32'h0);
    in_port = 4'h0;
    tick(16);
    wr(2'd3, 32'hF);
    tick(2);
    rd(2'd3);
    check("settle_edgecap", v0, 32'h0);
    check("settle_edgecap_any", v1, 32'h0);
    // rising edge on bit0 with mask set
    wr(2'd2, 32'h1);
    in_port = 4'h1;
    tick(LAT);
    check("t2_irq_early", {31'b0, irq0}, 32'h0);
    tick();
    check("t2_irq_set", {31'b0, irq0}, 32'h1);
    rd(2'd3);
    check("t2_edgecap", v0, 32'h1);
    wr(2'd3, 32'h1);
    check("t2_irq_hold", {31'b0, irq0}, 32'h1);
    tick();
    check("t2_irq_clr", {31'b0, irq0}, 32'h0);
    // masked capture, then unmask
    wr(2'd2, 32'h0);
    in_port = 4'h5;
    tick(LAT + 2);
    rd(2'd3);
    check("t3_edgecap", v0, 32'h4);
    check("t3_irq_masked", {31'b0, irq0}, 32'h0);
    wr(2'd2, 32'h4);
    check("t3_irq_lag", {31'b0, irq0}, 32'h0);
    tick();
    check("t3_irq_unmask", {31'b0, irq0}, 32'h1);
    wr(2'd3, 32'h8);
    rd(2'd3);
    check("t3_w1c_other", v0, 32'h4);
    wr(2'd3, 32'h4);
    // edge and clear on the same clock
    in_port = 4'h7;
    tick(LAT - 1);
    wr(2'd3, 32'h2);
    rd(2'd3);
    check("t4_set_wins", v0, 32'h2);
    wr(2'd3, 32'h2);
    rd(2'd3);
    check("t4_cleared", v0, 32'h0);
    // any-edge instance against rising-only instance
    wr(2'd3, 32'hF);
    in_port = 4'hF;
    tick(LAT + 1);
    rd(2'd3);
    check("t5_rise", v0, 32'h8);
    check("t5_rise_any", v1, 32'h8);
    wr(2'd3, 32'h8);
    rd(2'd3);
    check("t5_clr_any", v1, 32'h0);
    in_port = 4'h7;
    tick(LAT + 1);
    rd(2'd3);
    check("t5_fall_rise_only", v0, 32'h0);
    check("t5_fall_any", v1, 32'h8);
    rd(2'd1);
    check("t5_rsvd", v0, 32'h0);
    wr(2'd0, 32'h0);
    rd(2'd0);
    check("t5_data_wr", v0, 32'h7);
    check("t5_data_wr_any", v1, 32'h7);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2);
    check("t5_mask_width", v0, 32'hF);
`ifdef MOTOR_SENSE_DEBOUNCE_EN
    wr(2'd2, 32'h0);
    wr(2'd3, 32'hF);
    in_port = 4'hF;
    tick(5);
    in_port = 4'h7;
    tick(15);
    rd(2'd0);
    check("t6_glitch_data", v0, 32'h7);
    rd(2'd3);
    check("t6_glitch_cap", v0, 32'h0);
    address = 2'd0;
    in_port = 4'hF;
    tick(10);
    check("t6_data_pending", rd0, 32'h7);
    tick();
    check("t6_data_change", rd0, 32'hF);
    tick();
    in_port = 4'h7;
    tick(15);
    rd(2'd3);
    check("t6_level_cap", v0, 32'h8);
    wr(2'd3, 32'hF);
    in_port = 4'h8;
    tick(7);
    reset_n = 1'b0;
    in_port = 4'h0;
    tick(2);
    reset_n = 1'b1;
    in_port = 4'h8;
    tick(6);
    in_port = 4'h0;
    tick(15);
    rd(2'd3);
    check("t6_reset_cap", v0, 32'h0);
    rd(2'd0);
    check("t6_reset_data", v0, 32'h0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
